// File: rtl/pipeline_stall_controller.sv
// Stall/flush/halt sequencer for a 5-stage pipeline: drives PC and IF/ID enables, IF/ID flush and ID/EX bubble.
// Optional hazard-stall performance counter enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
    parameter int STALL_CYCLES = 1,   // 1..7
    parameter int FLUSH_CYCLES = 2,   // 1..3
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             halt,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

    // The entry cycle is spent in RUN, so the counter covers the remaining cycles minus one.
    localparam logic [2:0] STALL_INIT = 3'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);
    localparam logic [2:0] FLUSH_INIT = 3'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       hz_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        hz_bubble   = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (hazard) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    hz_bubble   = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_INIT;
                    end
                end else if (halt) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = HALT;
                end
            end
            STALL: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                hz_bubble   = 1'b1;
                if (cnt_q == 3'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 3'd1;
            end
            FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (cnt_q == 3'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 3'd1;
            end
            HALT: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
            default: state_d = RUN;
        endcase
        // Reset holds the pipeline front end frozen with NOPs in flight.
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            hz_bubble   = 1'b0;
        end
    end

    assign busy = (state_q != RUN);

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (hz_bubble && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: table-driven default-config vectors plus hand sequences
// on STALL=3/FLUSH=3/CNT_W=4 and STALL=5 instances; expected outputs queued at drive, checked at negedge.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst_n, hazard, branch_taken, halt;
    always #5 clk = ~clk;

    // Output bundles {pc_we, ifid_we, ifid_flush, idex_bubble, busy}
    logic [4:0] o0, o1, o2;

`ifdef STALL_PERF_CNT_EN
    logic [15:0] sc0;
    logic [3:0]  sc1;
    logic [15:0] sc2;
`endif

    pipeline_stall_controller u_dut0 (
        .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken), .halt(halt),
        .pc_we(o0[4]), .ifid_we(o0[3]), .ifid_flush(o0[2]), .idex_bubble(o0[1]), .busy(o0[0])
`ifdef STALL_PERF_CNT_EN
        , .stall_count(sc0)
`endif
    );

    pipeline_stall_controller #(.STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken), .halt(halt),
        .pc_we(o1[4]), .ifid_we(o1[3]), .ifid_flush(o1[2]), .idex_bubble(o1[1]), .busy(o1[0])
`ifdef STALL_PERF_CNT_EN
        , .stall_count(sc1)
`endif
    );

    pipeline_stall_controller #(.STALL_CYCLES(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken), .halt(halt),
        .pc_we(o2[4]), .ifid_we(o2[3]), .ifid_flush(o2[2]), .idex_bubble(o2[1]), .busy(o2[0])
`ifdef STALL_PERF_CNT_EN
        , .stall_count(sc2)
`endif
    );

    localparam logic [4:0] IDLE = 5'b11000, STL = 5'b00010, STLB = 5'b00011;
    localparam logic [4:0] FLS  = 5'b11110, FLSB = 5'b11111, RSTV = 5'b00110, HLT = 5'b00011;

    typedef struct {
        logic       rst;
        logic       hz;
        logic       br;
        logic       hl;
        logic [4:0] exp;
        int         cnt;
    } vec_t;

    vec_t       tbl[18];
    logic [4:0] expq[$];
    int         checks = 0;
    int         failures = 0;

    function automatic vec_t mk(logic r, logic h, logic b, logic l, logic [4:0] e, int c);
        vec_t v;
        v.rst = r; v.hz = h; v.br = b; v.hl = l; v.exp = e; v.cnt = c;
        return v;
    endfunction

    task automatic drive(input logic r, input logic h, input logic b, input logic l, input logic [4:0] e);
        rst_n = r; hazard = h; branch_taken = b; halt = l;
        expq.push_back(e);
    endtask

    task automatic chk(input int sel, input string nm);
        logic [4:0] e, act;
        e = expq.pop_front();
        act = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s got=%b want=%b (pc_we,ifid_we,flush,bubble,busy)", nm, act, e);
        end
    endtask

    task automatic chk_cnt(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s stall_count got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int sel, input string nm, input logic r, input logic h,
                       input logic b, input logic l, input logic [4:0] e);
        drive(r, h, b, l, e);
        @(negedge clk);
        chk(sel, nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hazard = 1'b0; branch_taken = 1'b0; halt = 1'b0;

        // Default config: STALL_CYCLES=1, FLUSH_CYCLES=2
        tbl[0]  = mk(0, 0, 0, 0, RSTV, 0);
        tbl[1]  = mk(1, 0, 0, 0, IDLE, 0);
        tbl[2]  = mk(1, 1, 0, 0, STL,  0);
        tbl[3]  = mk(1, 0, 0, 0, IDLE, 1);
        tbl[4]  = mk(1, 1, 0, 0, STL,  1);
        tbl[5]  = mk(1, 1, 0, 0, STL,  2);
        tbl[6]  = mk(1, 0, 0, 0, IDLE, 3);
        tbl[7]  = mk(1, 1, 1, 0, FLS,  3);
        tbl[8]  = mk(1, 1, 0, 0, FLSB, 3);
        tbl[9]  = mk(1, 0, 0, 0, IDLE, 3);
        tbl[10] = mk(1, 0, 1, 1, FLS,  3);
        tbl[11] = mk(1, 0, 0, 1, FLSB, 3);
        tbl[12] = mk(1, 1, 0, 1, STL,  3);
        tbl[13] = mk(1, 0, 0, 1, STL,  4);
        tbl[14] = mk(1, 1, 1, 0, HLT,  4);
        tbl[15] = mk(1, 0, 0, 0, HLT,  4);
        tbl[16] = mk(0, 0, 0, 0, RSTV, 0);
        tbl[17] = mk(1, 0, 0, 0, IDLE, 0);

        #1;
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].hz, tbl[i].br, tbl[i].hl, tbl[i].exp);
            @(negedge clk);
            chk(0, $sformatf("tbl%0d", i));
`ifdef STALL_PERF_CNT_EN
            chk_cnt($sformatf("tbl%0d_cnt", i), int'(sc0), tbl[i].cnt);
`endif
            @(posedge clk);
            #1;
        end

        // STALL_CYCLES=3: one-cycle hazard pulse gives three bubbles
        cyc(1, "s3_rst", 0, 0, 0, 0, RSTV);
        cyc(1, "s3_c1",  1, 1, 0, 0, STL);
        cyc(1, "s3_c2",  1, 0, 1, 1, STLB);
        cyc(1, "s3_c3",  1, 0, 0, 0, STLB);
`ifdef STALL_PERF_CNT_EN
        chk_cnt("s3_total", int'(sc1), 3);
`endif
        cyc(1, "s3_run", 1, 0, 0, 0, IDLE);

        // FLUSH_CYCLES=3: branch flushes three cycles, hazard ignored while flushing
        cyc(1, "f3_c1",  1, 0, 1, 0, FLS);
        cyc(1, "f3_c2",  1, 1, 0, 0, FLSB);
        cyc(1, "f3_c3",  1, 1, 0, 0, FLSB);
`ifdef STALL_PERF_CNT_EN
        chk_cnt("f3_nocount", int'(sc1), 3);
`endif
        cyc(1, "f3_run", 1, 0, 0, 0, IDLE);

        // CNT_W=4: hazard held 20 cycles, back-to-back stalls, counter saturates
        cyc(1, "sat_rst", 0, 0, 0, 0, RSTV);
        for (int i = 0; i < 20; i++)
            cyc(1, $sformatf("sat%0d", i), 1, 1, 0, 0, (i % 3 == 0) ? STL : STLB);
`ifdef STALL_PERF_CNT_EN
        chk_cnt("sat_value", int'(sc1), 15);
`endif

        // STALL_CYCLES=5: async reset on the second stall cycle
        cyc(2, "r5_rst", 0, 0, 0, 0, RSTV);
        cyc(2, "r5_c1",  1, 1, 0, 0, STL);
        drive(1, 0, 0, 0, STLB);
        @(negedge clk);
        chk(2, "r5_c2");
        #1;
        rst_n = 1'b0;
        expq.push_back(RSTV);
        #1;
        chk(2, "r5_async");
`ifdef STALL_PERF_CNT_EN
        chk_cnt("r5_cnt_clr", int'(sc2), 0);
`endif
        @(posedge clk);
        #1;
        cyc(2, "r5_rel", 1, 0, 0, 0, IDLE);
        cyc(2, "r5_run", 1, 0, 0, 0, IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
